// File: rtl/aes_block_loader.sv
// Byte-serial loader that assembles an AES key and a 128-bit data block and hands them to the cipher.
// Optional macro AES_LOADER_BYTECNT_EN adds the bytes_loaded progress output.
module aes_block_loader #(
    parameter int DATA_BYTES    = 16,
    parameter int MAX_KEY_BYTES = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   mode,
    input  logic [7:0]                   in_byte,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         new_key,
    output logic [8*MAX_KEY_BYTES-1:0]   key_out,
    output logic [1:0]                   key_mode,
    output logic [8*DATA_BYTES-1:0]      data_out,
    output logic                         block_valid,
    input  logic                         block_ready,
`ifdef AES_LOADER_BYTECNT_EN
    output logic [5:0]                   bytes_loaded,
`endif
    output logic                         mode_err
);

    typedef enum logic [1:0] {
        LOAD_KEY  = 2'd0,
        LOAD_DATA = 2'd1,
        HOLD      = 2'd2
    } state_t;

    localparam int KW = 8 * MAX_KEY_BYTES;
    localparam int DW = 8 * DATA_BYTES;

    state_t          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [KW-1:0]   key_q, key_d;
    logic [DW-1:0]   data_q, data_d;
    logic [1:0]      key_mode_q, key_mode_d;
    logic            mode_err_q, mode_err_d;
    logic            accept;
    logic [1:0]      mode_eff;
    logic [5:0]      kb_last;

    // The first key byte latches the mode, so the terminal count must use the live mode then.
    always_comb begin
        mode_eff = (state_q == LOAD_KEY && cnt_q == 6'd0) ? mode : key_mode_q;
        case (mode_eff)
            2'b01:   kb_last = 6'd23;
            2'b10:   kb_last = 6'd31;
            default: kb_last = 6'd15;
        endcase
    end

    assign in_ready = (state_q != HOLD) && !new_key;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        key_d      = key_q;
        data_d     = data_q;
        key_mode_d = key_mode_q;
        mode_err_d = mode_err_q;
        case (state_q)
            LOAD_KEY: begin
                if (new_key) begin
                    cnt_d = 6'd0;
                end else if (accept) begin
                    if (cnt_q == 6'd0) begin
                        key_mode_d = mode;
                        if (mode == 2'b11) mode_err_d = 1'b1;
                        key_d = {{(KW-8){1'b0}}, in_byte};
                    end else begin
                        key_d = {key_q[KW-9:0], in_byte};
                    end
                    if (cnt_q == kb_last) begin
                        cnt_d   = 6'd0;
                        state_d = LOAD_DATA;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            LOAD_DATA: begin
                if (new_key) begin
                    cnt_d   = 6'd0;
                    state_d = LOAD_KEY;
                end else if (accept) begin
                    data_d = {data_q[DW-9:0], in_byte};
                    if (cnt_q == 6'(DATA_BYTES - 1)) begin
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            HOLD: begin
                if (block_ready) begin
                    cnt_d   = 6'd0;
                    state_d = LOAD_DATA;
                end
            end
            default: begin
                cnt_d   = 6'd0;
                state_d = LOAD_KEY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD_KEY;
            cnt_q      <= 6'd0;
            key_q      <= '0;
            data_q     <= '0;
            key_mode_q <= 2'b00;
            mode_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_q      <= key_d;
            data_q     <= data_d;
            key_mode_q <= key_mode_d;
            mode_err_q <= mode_err_d;
        end
    end

`ifdef AES_LOADER_BYTECNT_EN
    logic [5:0] bytes_q, bytes_d;

    // Restart on every phase change; entering HOLD shows the full block count.
    always_comb begin
        bytes_d = bytes_q;
        if (state_q != HOLD && new_key) begin
            bytes_d = 6'd0;
        end else if (state_d != state_q) begin
            bytes_d = (state_d == HOLD) ? 6'(DATA_BYTES) : 6'd0;
        end else if (accept) begin
            bytes_d = bytes_q + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) bytes_q <= 6'd0;
        else       bytes_q <= bytes_d;
    end

    assign bytes_loaded = bytes_q;
`endif

    assign key_out     = key_q;
    assign key_mode    = key_mode_q;
    assign data_out    = data_q;
    assign block_valid = (state_q == HOLD);
    assign mode_err    = mode_err_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed self-checking bench for aes_block_loader.
module tb_aes_block_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   mode;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_ready;
    logic         new_key;
    logic [255:0] key_out;
    logic [1:0]   key_mode;
    logic [127:0] data_out;
    logic         block_valid;
    logic         block_ready;
    logic         mode_err;
`ifdef AES_LOADER_BYTECNT_EN
    logic [5:0]   bytes_loaded;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [255:0] key_exp;
    logic [127:0] data_exp;

    always #5 clk = ~clk;

    aes_block_loader dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .new_key     (new_key),
        .key_out     (key_out),
        .key_mode    (key_mode),
        .data_out    (data_out),
        .block_valid (block_valid),
        .block_ready (block_ready),
`ifdef AES_LOADER_BYTECNT_EN
        .bytes_loaded(bytes_loaded),
`endif
        .mode_err    (mode_err)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_byte  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_new_key();
        in_valid = 1'b0;
        new_key  = 1'b1;
        tick();
        new_key  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mode = 2'b00; in_byte = 8'h00; in_valid = 1'b0;
        new_key = 1'b0; block_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", block_valid, 0);
        chk("rst_key", key_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_kmode", key_mode, 0);
        chk("rst_err", mode_err, 0);
        reset = 1'b0;
        tick();
        chk("rst_ready", in_ready, 1);
`ifdef AES_LOADER_BYTECNT_EN
        chk("rst_cnt", bytes_loaded, 0);
`endif

        // 128-bit key, then plaintext 00 11 .. ff
        for (int i = 0; i < 16; i++) send(8'(i));
        chk("k128_valid_early", block_valid, 0);
        for (int i = 0; i < 15; i++) send(8'(i * 17));
        chk("k128_valid_31", block_valid, 0);
        send(8'hff);
        in_valid = 1'b0;
        chk("k128_valid", block_valid, 1);
        chk("k128_key", key_out, 256'h000102030405060708090a0b0c0d0e0f);
        chk("k128_data", data_out, 128'h00112233445566778899aabbccddeeff);
        chk("k128_kmode", key_mode, 2'b00);
        chk("k128_ready_hold", in_ready, 0);
`ifdef AES_LOADER_BYTECNT_EN
        chk("k128_cnt_hold", bytes_loaded, 16);
`endif
        block_ready = 1'b1;
        tick();
        block_ready = 1'b0;
        chk("k128_valid_drop", block_valid, 0);
        chk("k128_ready_after", in_ready, 1);

        // 256-bit key with back-pressure
        pulse_new_key();
        mode = 2'b10;
        for (int i = 0; i < 32; i++) send(8'(i));
        for (int i = 0; i < 16; i++) send(8'(i * 17));
        in_valid = 1'b1; in_byte = 8'h5a;
        key_exp = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        for (int c = 0; c < 5; c++) begin
            chk("k256_key_stable", key_out, key_exp);
            chk("k256_data_stable", data_out, 128'h00112233445566778899aabbccddeeff);
            chk("k256_valid_stable", block_valid, 1);
            tick();
        end
        in_valid = 1'b0;
        chk("k256_kmode", key_mode, 2'b10);
        block_ready = 1'b1;
        tick();
        block_ready = 1'b0;
        chk("k256_valid_drop", block_valid, 0);
        chk("k256_ready_after", in_ready, 1);

        // Second block reuses the key
        for (int i = 0; i < 16; i++) send(8'(8'hff - i));
        in_valid = 1'b0;
        chk("blk2_valid", block_valid, 1);
        chk("blk2_key", key_out, key_exp);
        chk("blk2_data", data_out, 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0);
        block_ready = 1'b1;
        tick();
        block_ready = 1'b0;

        // 192-bit key, partial data, rekey with a discarded byte
        pulse_new_key();
        chk("rekey_key_held", key_out, key_exp);
        mode = 2'b01;
        send(8'h40);
        mode = 2'b00;
        for (int i = 1; i < 24; i++) send(8'(8'h40 + i));
        chk("k192_key", key_out, 256'h404142434445464748494a4b4c4d4e4f5051525354555657);
        chk("k192_kmode", key_mode, 2'b01);
        for (int i = 0; i < 7; i++) send(8'h33);
        in_byte = 8'haa; in_valid = 1'b1; new_key = 1'b1;
        #1;
        chk("nk_ready_low", in_ready, 0);
        tick();
        new_key = 1'b0; in_valid = 1'b0;
        chk("nk_key_held", key_out, 256'h404142434445464748494a4b4c4d4e4f5051525354555657);
        mode = 2'b01;
        send(8'h80);
        chk("nk_first_byte", key_out, 256'h80);
        for (int i = 1; i < 24; i++) send(8'(8'h80 + i));
        chk("nk_key", key_out, 256'h808182838485868788898a8b8c8d8e8f9091929394959697);
        for (int i = 0; i < 15; i++) send(8'(8'h10 + i));
        chk("nk_valid_15", block_valid, 0);
        send(8'h1f);
        in_valid = 1'b0;
        chk("nk_valid", block_valid, 1);
        chk("nk_data", data_out, 128'h101112131415161718191a1b1c1d1e1f);
        chk("nk_kmode", key_mode, 2'b01);
        chk("nk_err", mode_err, 0);
        block_ready = 1'b1;
        tick();
        block_ready = 1'b0;

        // Reserved mode behaves as 128-bit and flags an error
        pulse_new_key();
        mode = 2'b11;
        for (int i = 0; i < 16; i++) send(8'(8'hc0 + i));
        mode = 2'b00;
        for (int i = 0; i < 16; i++) send(8'(i * 17));
        in_valid = 1'b0;
        chk("m11_valid", block_valid, 1);
        chk("m11_kmode", key_mode, 2'b11);
        chk("m11_key", key_out, 256'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf);
        chk("m11_err", mode_err, 1);
        block_ready = 1'b1;
        tick();
        block_ready = 1'b0;
        chk("m11_err_sticky", mode_err, 1);

        // Reset while a block is waiting and the consumer is ready
        for (int i = 0; i < 16; i++) send(8'h77);
        in_valid = 1'b0;
        chk("rh_valid", block_valid, 1);
        block_ready = 1'b1; reset = 1'b1;
        tick();
        block_ready = 1'b0; reset = 1'b0;
        chk("rh_valid_drop", block_valid, 0);
        chk("rh_key", key_out, 0);
        chk("rh_data", data_out, 0);
        chk("rh_err", mode_err, 0);
        chk("rh_ready", in_ready, 1);
        tick();
        chk("rh_still_idle", block_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
